// File: rtl/reg_file_8x8.sv
// Eight-entry signed register file feeding both ALU operands and taking ALU write-back.
// Latency: one cycle for reads, with same-edge write bypass; writes land on the sampling edge.
// Backpressure: none, one write and one dual read per cycle; READ low holds OUT1/OUT2.
module reg_file_8x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    input  logic              READ,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic [DEPTH-1:0]  WRITTEN
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] rd1_dat;
    logic [DATA_W-1:0] rd2_dat;
    logic              byp1;
    logic              byp2;

    // A read of the register being written this edge returns the new value.
    always_comb begin
        byp1    = WRITE && (OUT1ADDRESS == INADDRESS);
        byp2    = WRITE && (OUT2ADDRESS == INADDRESS);
        rd1_dat = byp1 ? IN : regs[OUT1ADDRESS];
        rd2_dat = byp2 ? IN : regs[OUT2ADDRESS];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            WRITTEN <= '0;
        end else if (WRITE) begin
            regs[INADDRESS]    <= IN;
            WRITTEN[INADDRESS] <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            OUT1 <= '0;
            OUT2 <= '0;
        end else if (READ) begin
            OUT1 <= rd1_dat;
            OUT2 <= rd2_dat;
        end
    end

endmodule
